// File: rtl/sd_cmd_tx_if.sv
// Sequencer-side handshake of the SD CMD-line transmitter.
// Signal names keep the original port names so existing connections map one-to-one.
interface sd_cmd_tx_if;
  logic        start_i;
  logic        ready_o;
  logic [5:0]  cmd_index_i;
  logic [31:0] cmd_arg_i;
  logic        done_o;

  modport master (
    output start_i, cmd_index_i, cmd_arg_i,
    input  ready_o, done_o
  );

  modport slave (
    input  start_i, cmd_index_i, cmd_arg_i,
    output ready_o, done_o
  );
endinterface

// File: rtl/sd_cmd_tx.sv
// SD CMD-line transmitter: serialises one 48-bit command frame with on-the-fly CRC7.
// Optional Ncc gap after the frame: define SD_CMD_TX_NCC_GAP_EN.
module sd_cmd_tx #(
  parameter int unsigned FRAME_BITS = 48
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sd_clk_en_i,
  sd_cmd_tx_if.slave seq,
  output logic       cmd_o,
  output logic       cmd_oe_o
);

  localparam int unsigned CW = $clog2(FRAME_BITS);
`ifdef SD_CMD_TX_NCC_GAP_EN
  localparam int unsigned NCC_EDGES = 8;
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [39:0]   hdr, hdr_d;
  logic [6:0]    crc, crc_d;
  logic          tail, tail_d;
  logic          cmd_d, oe_d, done_q, done_d;
  logic          accept;

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  assign accept      = seq.start_i && (state == IDLE);
  assign seq.ready_o = (state == IDLE);
  assign seq.done_o  = done_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_d;
  end

  // tail marks that bit0 is on the line; the next enabled edge releases it.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:  if (accept) state_d = SHIFT;
      SHIFT: if (sd_clk_en_i && tail) begin
`ifdef SD_CMD_TX_NCC_GAP_EN
        state_d = GAP;
`else
        state_d = IDLE;
`endif
      end
`ifdef SD_CMD_TX_NCC_GAP_EN
      GAP:   if (sd_clk_en_i && (cnt == '0)) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt;
    hdr_d  = hdr;
    crc_d  = crc;
    tail_d = tail;
    cmd_d  = cmd_o;
    oe_d   = cmd_oe_o;
    done_d = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          hdr_d  = {2'b01, seq.cmd_index_i, seq.cmd_arg_i};
          crc_d  = '0;
          cnt_d  = CW'(FRAME_BITS - 1);
          tail_d = 1'b0;
        end
      end
      SHIFT: begin
        if (sd_clk_en_i) begin
          if (tail) begin
            oe_d   = 1'b0;
            cmd_d  = 1'b1;
            tail_d = 1'b0;
`ifdef SD_CMD_TX_NCC_GAP_EN
            cnt_d  = CW'(NCC_EDGES - 1);
`else
            done_d = 1'b1;
`endif
          end else begin
            oe_d = 1'b1;
            if (cnt >= CW'(8)) begin
              // Header bits feed the CRC as they leave; CRC then shifts out frozen.
              cmd_d = hdr[39];
              hdr_d = {hdr[38:0], 1'b0};
              crc_d = crc7_step(crc, hdr[39]);
            end else if (cnt != '0) begin
              cmd_d = crc[6];
              crc_d = {crc[5:0], 1'b0};
            end else begin
              cmd_d  = 1'b1;
              tail_d = 1'b1;
            end
            if (cnt != '0) cnt_d = cnt - CW'(1);
          end
        end
      end
`ifdef SD_CMD_TX_NCC_GAP_EN
      GAP: begin
        if (sd_clk_en_i) begin
          if (cnt == '0) done_d = 1'b1;
          else           cnt_d  = cnt - CW'(1);
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt      <= '0;
      hdr      <= '0;
      crc      <= '0;
      tail     <= 1'b0;
      cmd_o    <= 1'b1;
      cmd_oe_o <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      cnt      <= cnt_d;
      hdr      <= hdr_d;
      crc      <= crc_d;
      tail     <= tail_d;
      cmd_o    <= cmd_d;
      cmd_oe_o <= oe_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_sd_cmd_tx.sv
// Directed bench for sd_cmd_tx: table of known SD command frames plus reset-abort sequence.
module tb_sd_cmd_tx;

`ifdef SD_CMD_TX_NCC_GAP_EN
  localparam int NCC = 8;
`else
  localparam int NCC = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic sd_clk_en;
  logic cmd, cmd_oe;
  int   checks = 0;
  int   errors = 0;

  sd_cmd_tx_if bus ();

  sd_cmd_tx #(.FRAME_BITS(48)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .sd_clk_en_i(sd_clk_en),
    .seq        (bus.slave),
    .cmd_o      (cmd),
    .cmd_oe_o   (cmd_oe)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    int          period;
    int          pause_len;
    bit          poke;
    logic [47:0] frame;
    logic [6:0]  crc;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic tx(input vec_t v);
    logic [47:0] got;
    int  bits, oe_cyc, first_oe, c, gap_edges, hold_err, rdy_err, paused;
    bit  released, done_seen, en_was;
    logic prev_cmd, prev_oe;
    got = '0; bits = 0; oe_cyc = 0; first_oe = -1; c = 0; gap_edges = 0;
    hold_err = 0; rdy_err = 0; paused = 0; released = 0; done_seen = 0;

    @(negedge clk);
    chk("accept_ready", {63'd0, bus.ready_o}, 64'd1);
    bus.cmd_index_i = v.idx;
    bus.cmd_arg_i   = v.arg;
    bus.start_i     = 1'b1;
    sd_clk_en       = 1'b0;
    @(posedge clk); #1;
    bus.start_i     = 1'b0;
    bus.cmd_index_i = ~v.idx;
    bus.cmd_arg_i   = ~v.arg;
    chk("ready_drop", {63'd0, bus.ready_o}, 64'd0);
    chk("accept_edge_outputs", {62'd0, cmd_oe, cmd}, 64'd1);
    chk("done_pulse_len", {63'd0, bus.done_o}, 64'd0);
    prev_cmd = cmd;
    prev_oe  = cmd_oe;

    while (!done_seen && c < 3000) begin
      @(negedge clk);
      c++;
      if (v.pause_len > 0 && bits == 20 && paused < v.pause_len) begin
        sd_clk_en = 1'b0;
        paused++;
      end else begin
        sd_clk_en = ((c % v.period) == 0);
      end
      bus.start_i = v.poke && (bits == 24);
      en_was = sd_clk_en;
      @(posedge clk); #1;
      if (cmd_oe) begin
        oe_cyc++;
        if (first_oe < 0) first_oe = c;
      end
      if (!en_was && (cmd !== prev_cmd || cmd_oe !== prev_oe)) hold_err++;
      if (en_was && cmd_oe) begin
        got = {got[46:0], cmd};
        bits++;
      end
      if (en_was && released) gap_edges++;
      if (en_was && !cmd_oe && prev_oe) released = 1'b1;
      if (!bus.done_o && bus.ready_o) rdy_err++;
      if (bus.done_o) done_seen = 1'b1;
      prev_cmd = cmd;
      prev_oe  = cmd_oe;
    end
    bus.start_i = 1'b0;

    chk("done_seen", {63'd0, done_seen}, 64'd1);
    chk("frame", {16'd0, got}, {16'd0, v.frame});
    chk("crc7", {57'd0, got[7:1]}, {57'd0, v.crc});
    chk("enabled_bits", bits, 48);
    chk("oe_cycles", oe_cyc, 48 * v.period + v.pause_len);
    chk("first_oe_latency", first_oe, v.period);
    chk("hold_between_edges", hold_err, 0);
    chk("ready_low_busy", rdy_err, 0);
    chk("gap_edges_at_done", gap_edges, NCC);
    chk("done_line_released", {62'd0, cmd_oe, cmd}, 64'd1);
    chk("done_with_ready", {63'd0, bus.ready_o}, 64'd1);
  endtask

  initial begin
    tbl[0] = '{6'd0,  32'h0000_0000, 1, 0,   1'b0, 48'h40_0000_0000_95, 7'h4A};
    tbl[1] = '{6'd8,  32'h0000_01AA, 4, 0,   1'b0, 48'h48_0000_01AA_87, 7'h43};
    tbl[2] = '{6'd17, 32'h0000_0000, 1, 0,   1'b1, 48'h51_0000_0000_55, 7'h2A};
    tbl[3] = '{6'd55, 32'h0000_0000, 1, 100, 1'b0, 48'h77_0000_0000_65, 7'h32};
    tbl[4] = '{6'd0,  32'h0000_0000, 3, 0,   1'b0, 48'h40_0000_0000_95, 7'h4A};

    rst = 1'b1;
    sd_clk_en = 1'b0;
    bus.start_i = 1'b0;
    bus.cmd_index_i = '0;
    bus.cmd_arg_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {60'd0, cmd_oe, cmd, bus.ready_o, bus.done_o}, 64'b0110);
    @(negedge clk);
    rst = 1'b0;
    sd_clk_en = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("idle_quiet", {60'd0, cmd_oe, cmd, bus.ready_o, bus.done_o}, 64'b0110);

    // back-to-back: each tx accepts in the cycle its predecessor pulsed done
    for (int i = 0; i < 5; i++) tx(tbl[i]);

    // reset abort mid-frame
    @(negedge clk);
    bus.cmd_index_i = 6'd17;
    bus.cmd_arg_i   = '0;
    bus.start_i     = 1'b1;
    sd_clk_en       = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("midframe_oe", {63'd0, cmd_oe}, 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_state", {60'd0, cmd_oe, cmd, bus.ready_o, bus.done_o}, 64'b0110);
    @(negedge clk);
    rst = 1'b0;
    tx(tbl[1]);
    tx(tbl[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
